// File: rtl/seq_div_8.sv
// Sequential unsigned restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero returns all-ones quotient and the dividend as remainder.
module seq_div_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   // The partial remainder is always < divisor, so its top bit is implicitly
   // zero; the shifted value and the trial difference carry the extra bit.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;

      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               if (B != '0) begin
                  quo_d   = A;
                  dvs_d   = B;
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH);
                  busy_d  = 1'b1;
                  dbz_d   = 1'b0;
                  state_d = CALC;
               end else begin
                  q_d     = '1;
                  r_d     = A;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end

         CALC: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               q_d     = quo_d;
               r_d     = rem_d;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            // The divide-by-zero path arrives here without done raised and
            // spends one extra cycle so its pulse lands on the second edge.
            if (!done_q) begin
               done_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign Q           = q_q;
   assign R           = r_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_8.sv
// Scoreboard bench for seq_div_8: the driver pushes expected results, a monitor
// pops and checks them on every done pulse; the driver also checks latency and handshake.
module tb_seq_div_8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] A, B;
   logic [7:0] Q, R;
   logic       busy, done, div_by_zero;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_div_8 #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk(Q === e.q, $sformatf("Q a=%0d b=%0d", e.a, e.b), Q, e.q);
            chk(R === e.r, $sformatf("R a=%0d b=%0d", e.a, e.b), R, e.r);
            chk(div_by_zero === e.dbz, $sformatf("dbz a=%0d b=%0d", e.a, e.b), div_by_zero, e.dbz);
            if (e.b != 0)
               chk(int'(Q) * int'(e.b) + int'(R) == int'(e.a),
                   $sformatf("QB+R a=%0d b=%0d", e.a, e.b), int'(Q) * int'(e.b) + int'(R), e.a);
            $display("txn a=%0d b=%0d -> Q=%0d R=%0d dbz=%0d", e.a, e.b, Q, R, div_by_zero);
         end
      end
   end

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 0) begin
         e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Issue one division and check latency, busy behaviour, result hold and pulse width.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input exp_t e);
      int         edges;
      int         lat;
      bit         saw_busy;
      bit         hold_bad;
      logic [7:0] q_prev;
      logic [7:0] r_prev;
      exp_q.push_back(e);
      @(negedge clk);
      q_prev = Q;
      r_prev = R;
      start = 1'b1; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; A = 8'hxx; B = 8'hxx;
      edges = 1;
      saw_busy = busy;
      hold_bad = (b != 0) && (Q !== q_prev || R !== r_prev);
      lat = (b == 0) ? 2 : 9;
      while (!done && edges < 20) begin
         @(posedge clk); #1;
         edges++;
         if (busy) saw_busy = 1'b1;
         if (b != 0 && !done && (Q !== q_prev || R !== r_prev)) hold_bad = 1'b1;
      end
      chk(edges == lat, $sformatf("latency a=%0d b=%0d", a, b), edges, lat);
      chk(saw_busy == (b != 0), $sformatf("busy a=%0d b=%0d", a, b), saw_busy, b != 0);
      if (b != 0) chk(!hold_bad, $sformatf("hold a=%0d b=%0d", a, b), hold_bad, 0);
      @(posedge clk); #1;
      chk(done == 1'b0, "done_one_cycle", done, 0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } vec_t;

   // Hand-computed directed vectors.
   vec_t vecs[] = '{
      '{8'd143, 8'd11,  8'd13,  8'd0,   1'b0},
      '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0},
      '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0},
      '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0},
      '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1},
      '{8'd60,  8'd6,   8'd10,  8'd0,   1'b0},
      '{8'd0,   8'd13,  8'd0,   8'd0,   1'b0},
      '{8'd77,  8'd77,  8'd1,   8'd0,   1'b0},
      '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0},
      '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0},
      '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0},
      '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1}
   };

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      chk(Q == 0 && R == 0, "reset_QR", {Q, R}, 0);
      chk(busy == 0 && done == 0 && div_by_zero == 0, "reset_flags", {busy, done, div_by_zero}, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         e.a = vecs[i].a; e.b = vecs[i].b; e.q = vecs[i].q; e.r = vecs[i].r; e.dbz = vecs[i].dbz;
         run_div(vecs[i].a, vecs[i].b, e);
      end

      // Divide-by-zero flag clears on the next good division.
      e.a = 8'd100; e.b = 8'd0; e.q = 8'd255; e.r = 8'd100; e.dbz = 1'b1;
      run_div(8'd100, 8'd0, e);
      e.a = 8'd9; e.b = 8'd4; e.q = 8'd2; e.r = 8'd1; e.dbz = 1'b0;
      run_div(8'd9, 8'd4, e);

      // A start raised mid-calculation is ignored.
      e.a = 8'd250; e.b = 8'd3; e.q = 8'd83; e.r = 8'd1; e.dbz = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1; A = 8'd250; B = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; A = 8'd9; B = 8'd9;
      @(negedge clk);
      start = 1'b0; A = '0; B = '0;
      repeat (15) @(negedge clk);
      chk(exp_q.size() == 0, "ignored_start_result", exp_q.size(), 0);
      chk(busy == 0, "ignored_start_idle", busy, 0);

      // Reset mid-calculation aborts without a done pulse.
      @(negedge clk);
      start = 1'b1; A = 8'd77; B = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk(busy == 1, "abort_busy_before", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk(Q == 0 && R == 0, "abort_QR", {Q, R}, 0);
      chk(busy == 0 && done == 0 && div_by_zero == 0, "abort_flags", {busy, done, div_by_zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      e.a = 8'd77; e.b = 8'd5; e.q = 8'd15; e.r = 8'd2; e.dbz = 1'b0;
      run_div(8'd77, 8'd5, e);

      // Strided sweep across the operand space, including B=0 and the top value.
      for (int a = 0; a <= 255; a += 15) begin
         for (int b = 0; b <= 255; b += 17) begin
            run_div(8'(a), 8'(b), model(8'(a), 8'(b)));
         end
      end

      repeat (5) @(negedge clk);
      chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
